// File: rtl/mfp_vga_scanout.sv
// VGA scanout engine: generates display timing from HCLK via a pixel-enable divider,
// reads pixels from VRAM port b and drives registered RGB444 plus sync to the connector.
module mfp_vga_scanout #(
    parameter int CLK_DIV  = 2,
    parameter int RAM_LAT  = 1,
    parameter int H_VIS    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_VIS    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    output logic [18:0] IO_VGA_ADDR,
    input  logic [11:0] IO_VGA_DATA,
    output logic [3:0]  VGA_R,
    output logic [3:0]  VGA_G,
    output logic [3:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        FRAME_START,
    output logic        VBLANK
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [11:0] H_LAST   = 12'(H_TOT - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOT - 1);
    localparam logic [11:0] H_VIS_C  = 12'(H_VIS);
    localparam logic [11:0] V_VIS_C  = 12'(V_VIS);
    localparam logic [11:0] H_SS     = 12'(H_VIS + H_FP);
    localparam logic [11:0] H_SE     = 12'(H_VIS + H_FP + H_SYNC);
    localparam logic [11:0] V_SS     = 12'(V_VIS + V_FP);
    localparam logic [11:0] V_SE     = 12'(V_VIS + V_FP + V_SYNC);
    localparam logic        SYNC_ACT  = SYNC_POL;
    localparam logic        SYNC_IDLE = ~SYNC_POL;

    // Data must settle within one pixel period of the address changing.
    if (CLK_DIV < RAM_LAT + 1) begin : g_bad_div
        $error("CLK_DIV must be at least RAM_LAT+1");
    end

    logic [7:0]  r_div_cnt;
    logic [11:0] r_h_cnt;
    logic [11:0] r_v_cnt;
    logic [18:0] r_addr;
    logic [11:0] r_rgb;
    logic        r_hs;
    logic        r_vs;
    logic        r_frame_start;
    logic        r_vblank;

    logic w_pe;
    logic w_h_last;
    logic w_v_last;
    logic w_visible;
    logic w_next_zero;
    logic w_hs_act;
    logic w_vs_act;

    assign w_pe        = (r_div_cnt == DIV_LAST);
    assign w_h_last    = (r_h_cnt == H_LAST);
    assign w_v_last    = (r_v_cnt == V_LAST);
    assign w_visible   = (r_h_cnt < H_VIS_C) && (r_v_cnt < V_VIS_C);
    assign w_next_zero = w_h_last && w_v_last;
    assign w_hs_act    = (r_h_cnt >= H_SS) && (r_h_cnt < H_SE);
    assign w_vs_act    = (r_v_cnt >= V_SS) && (r_v_cnt < V_SE);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_div_cnt     <= '0;
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_addr        <= '0;
            r_rgb         <= '0;
            r_hs          <= SYNC_IDLE;
            r_vs          <= SYNC_IDLE;
            r_frame_start <= 1'b0;
            r_vblank      <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            r_div_cnt     <= w_pe ? 8'd0 : r_div_cnt + 8'd1;
            if (w_pe) begin
                r_h_cnt <= w_h_last ? 12'd0 : r_h_cnt + 12'd1;
                if (w_h_last) begin
                    r_v_cnt <= w_v_last ? 12'd0 : r_v_cnt + 12'd1;
                end
                // Address runs one pixel ahead of the output stage so it can absorb RAM latency.
                if (w_next_zero) begin
                    r_addr <= '0;
                end else if (w_visible) begin
                    r_addr <= r_addr + 19'd1;
                end
                r_rgb         <= w_visible ? IO_VGA_DATA : 12'd0;
                r_hs          <= w_hs_act ? SYNC_ACT : SYNC_IDLE;
                r_vs          <= w_vs_act ? SYNC_ACT : SYNC_IDLE;
                r_vblank      <= (r_v_cnt >= V_VIS_C);
                r_frame_start <= w_next_zero;
            end
        end
    end

    assign IO_VGA_ADDR = r_addr;
    assign VGA_R       = r_rgb[11:8];
    assign VGA_G       = r_rgb[7:4];
    assign VGA_B       = r_rgb[3:0];
    assign VGA_HS      = r_hs;
    assign VGA_VS      = r_vs;
    assign FRAME_START = r_frame_start;
    assign VBLANK      = r_vblank;

endmodule

// File: tb/tb_mfp_vga_scanout.sv
// Self-checking bench: a shrunk-timing instance checked cycle by cycle against a positional
// model with random VRAM contents and random mid-frame resets, plus a default-timing instance.
module tb_mfp_vga_scanout;

    typedef struct {
        int addr;
        int hs;
        int vs;
        int fs;
        int vb;
        int vis;
        int pidx;
    } exp_t;

    typedef struct {
        int n;
        int addr;
        int hs;
        int vs;
        int fs;
        int vb;
    } vec_t;

    logic clk = 1'b0;
    logic rst_s = 1'b1;
    logic rst_d = 1'b1;

    logic [18:0] addr_s, addr_d;
    logic [11:0] data_s, data_d;
    logic [3:0]  r_s, g_s, b_s, r_d, g_d, b_d;
    logic        hs_s, vs_s, fs_s, vb_s, hs_d, vs_d, fs_d, vb_d;

    logic [11:0] mem [0:32];

    int vectors = 0;
    int miscompares = 0;
    int n_s = 0;
    int n_d = 0;
    bit chk_d = 1'b1;
    bit tbl_on = 1'b1;
    vec_t tv [13];

    always #5 clk = ~clk;

    // Small timing: H 8/2/3/2 (15), V 4/1/2/1 (8), 240 HCLK per frame.
    mfp_vga_scanout #(
        .CLK_DIV(2), .RAM_LAT(1),
        .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b0)
    ) u_small (
        .HCLK(clk), .HRESET(rst_s),
        .IO_VGA_ADDR(addr_s), .IO_VGA_DATA(data_s),
        .VGA_R(r_s), .VGA_G(g_s), .VGA_B(b_s),
        .VGA_HS(hs_s), .VGA_VS(vs_s),
        .FRAME_START(fs_s), .VBLANK(vb_s)
    );

    mfp_vga_scanout u_dflt (
        .HCLK(clk), .HRESET(rst_d),
        .IO_VGA_ADDR(addr_d), .IO_VGA_DATA(data_d),
        .VGA_R(r_d), .VGA_G(g_d), .VGA_B(b_d),
        .VGA_HS(hs_d), .VGA_VS(vs_d),
        .FRAME_START(fs_d), .VBLANK(vb_d)
    );

    // VRAM port b models, one cycle of read latency.
    always @(posedge clk) begin
        data_s <= (addr_s < 19'd33) ? mem[addr_s] : 12'h000;
        data_d <= addr_d[11:0];
    end

    // n = rising edges since reset release. Outputs describe the pixel before the latest pe;
    // the address equals the count of visible pixels already passed in this frame.
    function automatic exp_t model(int n, int hv, int hf, int hsy, int hb,
                                   int vv, int vf, int vsy, int vbp, int div);
        exp_t e;
        int ht, vt, ft, p, pos, h, v, prev, ph, pv;
        ht = hv + hf + hsy + hb;
        vt = vv + vf + vsy + vbp;
        ft = ht * vt;
        p = n / div;
        pos = p % ft;
        h = pos % ht;
        v = pos / ht;
        e.addr = (v < vv) ? v * hv + ((h < hv) ? h : hv) : vv * hv;
        e.hs = 1; e.vs = 1; e.fs = 0; e.vb = 0; e.vis = 0; e.pidx = 0;
        if (p > 0) begin
            prev = (p - 1) % ft;
            ph = prev % ht;
            pv = prev / ht;
            e.vis  = (ph < hv && pv < vv) ? 1 : 0;
            e.pidx = pv * hv + ph;
            e.hs   = (ph >= hv + hf && ph < hv + hf + hsy) ? 0 : 1;
            e.vs   = (pv >= vv + vf && pv < vv + vf + vsy) ? 0 : 1;
            e.vb   = (pv >= vv) ? 1 : 0;
            e.fs   = (n % div == 0 && pos == 0) ? 1 : 0;
        end
        return e;
    endfunction

    task automatic cmp(string nm, int n, int act, int exp_v);
        vectors++;
        if (act != exp_v) begin
            miscompares++;
            $display("FAIL %s at n=%0d: got %0d (0x%0h), expected %0d (0x%0h)",
                     nm, n, act, act, exp_v, exp_v);
        end
    endtask

    task automatic check_small(int n);
        exp_t e;
        int rgb;
        e = model(n, 8, 2, 3, 2, 4, 1, 2, 1, 2);
        rgb = e.vis ? int'(mem[e.pidx]) : 0;
        cmp("s_addr", n, int'(addr_s), e.addr);
        cmp("s_hs", n, int'(hs_s), e.hs);
        cmp("s_vs", n, int'(vs_s), e.vs);
        cmp("s_fs", n, int'(fs_s), e.fs);
        cmp("s_vblank", n, int'(vb_s), e.vb);
        cmp("s_rgb", n, int'({r_s, g_s, b_s}), rgb);
    endtask

    task automatic check_def(int n);
        exp_t e;
        int rgb;
        e = model(n, 640, 16, 96, 48, 480, 10, 2, 33, 2);
        rgb = e.vis ? (e.pidx & 12'hfff) : 0;
        cmp("d_addr", n, int'(addr_d), e.addr);
        cmp("d_hs", n, int'(hs_d), e.hs);
        cmp("d_vs", n, int'(vs_d), e.vs);
        cmp("d_fs", n, int'(fs_d), e.fs);
        cmp("d_vblank", n, int'(vb_d), e.vb);
        cmp("d_rgb", n, int'({r_d, g_d, b_d}), rgb);
        // Pixel (5,2) at 640 wide is address 1285, so it shows 12'h505.
        if (n == 3212) cmp("d_rgb_5_2", n, int'({r_d, g_d, b_d}), 32'h505);
    endtask

    task automatic check_table(int n);
        for (int i = 0; i < 13; i++) begin
            if (tv[i].n == n) begin
                cmp("t_addr", n, int'(addr_s), tv[i].addr);
                cmp("t_hs", n, int'(hs_s), tv[i].hs);
                cmp("t_vs", n, int'(vs_s), tv[i].vs);
                cmp("t_fs", n, int'(fs_s), tv[i].fs);
                cmp("t_vblank", n, int'(vb_s), tv[i].vb);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        n_s++;
        n_d++;
        check_small(n_s);
        if (tbl_on) check_table(n_s);
        if (chk_d) check_def(n_d);
    endtask

    initial begin
        // Hand-derived points on the small timing: {n, addr, hs, vs, fs, vblank}.
        tv[0]  = '{0,   0,  1, 1, 0, 0};
        tv[1]  = '{1,   0,  1, 1, 0, 0};
        tv[2]  = '{2,   1,  1, 1, 0, 0};
        tv[3]  = '{16,  8,  1, 1, 0, 0};
        tv[4]  = '{22,  8,  0, 1, 0, 0};
        tv[5]  = '{28,  8,  1, 1, 0, 0};
        tv[6]  = '{30,  8,  1, 1, 0, 0};
        tv[7]  = '{64,  18, 1, 1, 0, 0};
        tv[8]  = '{122, 32, 1, 1, 0, 1};
        tv[9]  = '{152, 32, 1, 0, 0, 1};
        tv[10] = '{240, 0,  1, 1, 1, 1};
        tv[11] = '{241, 0,  1, 1, 0, 1};
        tv[12] = '{242, 1,  1, 1, 0, 0};

        for (int i = 0; i < 33; i++) mem[i] = 12'($urandom);

        repeat (5) @(posedge clk);
        #1;
        check_small(0);
        check_table(0);
        check_def(0);
        @(negedge clk);
        rst_s = 1'b0;
        rst_d = 1'b0;

        // Default timing for four lines, small timing for many frames alongside.
        for (int c = 0; c < 6500; c++) step();
        chk_d = 1'b0;
        tbl_on = 1'b0;

        // Single-cycle resets at random points mid-frame; VRAM reloaded while held.
        for (int r = 0; r < 6; r++) begin
            int run;
            run = $urandom_range(600, 1);
            for (int c = 0; c < run; c++) step();
            @(negedge clk);
            rst_s = 1'b1;
            for (int i = 0; i < 33; i++) mem[i] = 12'($urandom);
            @(posedge clk);
            #1;
            check_small(0);
            @(negedge clk);
            rst_s = 1'b0;
            n_s = 0;
            for (int c = 0; c < 500; c++) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mfp_vga_scanout.md
Name: mfp_vga_scanout

Overview:
- Display-side reader of the VRAM; the AHB bus side writes the pixels.
- Generates 640x480@60 VGA timing from HCLK using a pixel-enable divider.
- Drives the VRAM read port address (IO_VGA_ADDR) and takes back the 12-bit pixel (IO_VGA_DATA).
- Registers aligned RGB444, hsync and vsync to the connector, plus a frame-start pulse and a vblank status bit for software.

Parameters:
- CLK_DIV, 2: HCLK cycles per pixel. Must be >= RAM_LAT+1.
- RAM_LAT, 1: VRAM read latency on port b, in HCLK cycles.
- H_VIS/H_FP/H_SYNC/H_BP, 640/16/96/48: horizontal timing in pixels. Total 800.
- V_VIS/V_FP/V_SYNC/V_BP, 480/10/2/33: vertical timing in lines. Total 525.
- SYNC_POL, 0: active level of hsync/vsync. 0 means active-low.

Ports:
- HCLK  in  1  system clock; all logic on its rising edge
- HRESET  in  1  synchronous, active-high reset
- IO_VGA_ADDR  out  19  VRAM read address; row-major, addr = y*640 + x
- IO_VGA_DATA  in  12  VRAM read data {R[11:8],G[7:4],B[3:0]}; valid RAM_LAT cycles after the address
- VGA_R  out  4  red
- VGA_G  out  4  green
- VGA_B  out  4  blue
- VGA_HS  out  1  horizontal sync
- VGA_VS  out  1  vertical sync
- FRAME_START  out  1  one-HCLK pulse when the counters wrap to (0,0)
- VBLANK  out  1  high while v_cnt >= V_VIS (registered)

Behaviour:
- Reset, synchronous on HRESET=1, all state reset together:
  - div_cnt=0, h_cnt=0, v_cnt=0, addr=0, FRAME_START=0, VBLANK=0.
  - VGA_R/G/B=0.
  - VGA_HS/VGA_VS at their inactive level (1 when SYNC_POL=0).
  - Asserting reset mid-frame aborts the frame; the next frame starts at (0,0) with addr 0.
- Pixel enable pe:
  - div_cnt counts 0..CLK_DIV-1 and wraps; pe=1 when div_cnt==CLK_DIV-1.
  - First pe falls in HCLK cycle CLK_DIV-1 after reset is released.
- Counters, advanced only on pe:
  - h_cnt counts 0..799 and wraps.
  - On h_cnt wrap, v_cnt counts 0..524 and wraps.
  - visible = (h_cnt<640)&&(v_cnt<480).
- Address register, updated on pe:
  - If the next position is (0,0): addr<=0.
  - Else if the current position is visible: addr<=addr+1.
  - Else addr holds.
  - Result: during the pixel period of visible (h,v), IO_VGA_ADDR = v*640+h.
  - During horizontal blank it already points to the next line start.
  - After the last pixel it holds 307200 until frame wrap. This address is harmless and never displayed.
- Output stage, registered on pe, for the position held before that pe edge:
  - VGA_R/G/B <= visible ? IO_VGA_DATA fields : 0.
  - VGA_HS active iff 656 <= h_cnt < 752.
  - VGA_VS active iff 490 <= v_cnt < 492.
  - VBLANK <= (v_cnt>=480).
  - Net effect: all connector outputs lag the counters by exactly one pixel period (CLK_DIV HCLK cycles) and are mutually aligned.
  - Data is sampled CLK_DIV cycles after the address changes, so CLK_DIV>RAM_LAT guarantees it is valid.
- FRAME_START: 1 for exactly one HCLK, in the cycle after the pe edge on which (h_cnt,v_cnt) became (0,0). 0 otherwise, including after reset.
- Outputs are constant between pe edges. No combinational path from IO_VGA_DATA to any output.
- Frame period: 800*525*CLK_DIV HCLK cycles, i.e. 840000 at the defaults. Line period: 1600 HCLK.

Test Plan:
- Reset: hold HRESET 5 cycles, release -> VGA_HS=VGA_VS=1, RGB=0, IO_VGA_ADDR=0, FRAME_START=0; first pe in cycle 1 after release.
- Horizontal timing: measure VGA_HS over 3 lines -> low for 192 HCLK, period 1600 HCLK, falling edge 1312 HCLK after active video starts.
- Vertical timing: run 2 frames -> VGA_VS low for 3200 HCLK per frame; FRAME_START pulses exactly 840000 HCLK apart; VBLANK high for 45 lines per frame.
- Address sequence: trace IO_VGA_ADDR -> 0..639 on line 0; holds 640 through blanking; 640..1279 on line 1; holds 307200 after pixel (639,479); returns to 0 at wrap.
- Data alignment: RAM model with RAM_LAT=1 returning data=addr[11:0] -> RGB at pixel (5,2) equals 1285[11:0]=12'h505 (R=5,G=0,B=5); RGB=0 during every blank pixel.
- Reset mid-frame: assert HRESET at line 200 pixel 300 for 1 cycle -> all outputs return to reset values next cycle; the next frame restarts with addr 0 and the correct sync timing.
